// File: rtl/vending_machine_ctrl_pkg.sv
// Shared definitions for the vending machine controller.
// Contents: FSM state type, coin denomination codes and values, the
// coin_value()/coin_valid_code() lookups and the price()/product_valid_code()
// product table lookups. No ports.
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } vm_state_e;

  // Denomination codes as carried on money / change_denomination_code
  localparam logic [3:0] DEN_1   = 4'd0;
  localparam logic [3:0] DEN_2   = 4'd1;
  localparam logic [3:0] DEN_5   = 4'd2;
  localparam logic [3:0] DEN_10  = 4'd3;
  localparam logic [3:0] DEN_20  = 4'd4;
  localparam logic [3:0] DEN_50  = 4'd5;
  localparam logic [3:0] DEN_100 = 4'd6;

  // Coin values in credit units; 7 bits covers the largest coin and price
  localparam int         VAL_W   = 7;
  localparam logic [6:0] VAL_1   = 7'd1;
  localparam logic [6:0] VAL_2   = 7'd2;
  localparam logic [6:0] VAL_5   = 7'd5;
  localparam logic [6:0] VAL_10  = 7'd10;
  localparam logic [6:0] VAL_20  = 7'd20;
  localparam logic [6:0] VAL_50  = 7'd50;
  localparam logic [6:0] VAL_100 = 7'd100;

  function automatic logic coin_valid_code(input logic [3:0] code);
    return (code <= DEN_100);
  endfunction

  function automatic logic [VAL_W-1:0] coin_value(input logic [3:0] code);
    case (code)
      DEN_1:   return VAL_1;
      DEN_2:   return VAL_2;
      DEN_5:   return VAL_5;
      DEN_10:  return VAL_10;
      DEN_20:  return VAL_20;
      DEN_50:  return VAL_50;
      DEN_100: return VAL_100;
      default: return '0;
    endcase
  endfunction

  function automatic logic product_valid_code(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  function automatic logic [VAL_W-1:0] price(input logic [3:0] code);
    case (code)
      4'd0:    return 7'd15;
      4'd1:    return 7'd20;
      4'd2:    return 7'd25;
      4'd3:    return 7'd30;
      4'd4:    return 7'd35;
      4'd5:    return 7'd40;
      4'd6:    return 7'd50;
      4'd7:    return 7'd65;
      4'd8:    return 7'd75;
      4'd9:    return 7'd100;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine_ctrl_if.sv
// Vending machine protocol bundle.
// Driver side (master) -> controller (slave):
//   money[3:0], money_valid, product_code[3:0], buy, product_ready
// Controller (slave) -> monitor side (master):
//   ready_product_code[3:0], product_valid, busy,
//   change_denomination_code[3:0], change_valid, no_change
interface vending_machine_ctrl_if;
  logic [3:0] money;
  logic       money_valid;
  logic [3:0] product_code;
  logic       buy;
  logic       product_ready;
  logic [3:0] ready_product_code;
  logic       product_valid;
  logic       busy;
  logic [3:0] change_denomination_code;
  logic       change_valid;
  logic       no_change;

  modport master (
    output money, money_valid, product_code, buy, product_ready,
    input  ready_product_code, product_valid, busy,
           change_denomination_code, change_valid, no_change
  );

  modport slave (
    input  money, money_valid, product_code, buy, product_ready,
    output ready_product_code, product_valid, busy,
           change_denomination_code, change_valid, no_change
  );
endinterface

// File: rtl/vending_machine_ctrl_change_sel.sv
// Greedy change selector (combinational).
// Ports:
//   i_rem     [CREDIT_W-1:0]  remaining change to pay
//   o_code    [3:0]           code of the largest coin <= i_rem (DEN_1 if 0)
//   o_value   [6:0]           value of that coin (0 when i_rem is 0)
module vm_change_sel
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 10
) (
  input  logic [CREDIT_W-1:0] i_rem,
  output logic [3:0]          o_code,
  output logic [VAL_W-1:0]    o_value
);

  always_comb begin
    o_code  = DEN_1;
    o_value = '0;
    if (i_rem >= CREDIT_W'(VAL_100)) begin
      o_code  = DEN_100;
      o_value = VAL_100;
    end else if (i_rem >= CREDIT_W'(VAL_50)) begin
      o_code  = DEN_50;
      o_value = VAL_50;
    end else if (i_rem >= CREDIT_W'(VAL_20)) begin
      o_code  = DEN_20;
      o_value = VAL_20;
    end else if (i_rem >= CREDIT_W'(VAL_10)) begin
      o_code  = DEN_10;
      o_value = VAL_10;
    end else if (i_rem >= CREDIT_W'(VAL_5)) begin
      o_code  = DEN_5;
      o_value = VAL_5;
    end else if (i_rem >= CREDIT_W'(VAL_2)) begin
      o_code  = DEN_2;
      o_value = VAL_2;
    end else if (i_rem != '0) begin
      o_code  = DEN_1;
      o_value = VAL_1;
    end
  end

endmodule

// File: rtl/vending_machine_ctrl.sv
// Vending machine controller.
// Accumulates coin credit, accepts a purchase once credit covers the price,
// offers the product until the dispenser acknowledges it, then returns the
// remainder greedily, one coin per cycle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   vm   protocol bundle (slave side): coin/buy/ack in, product/change out
module vending_machine_ctrl
  import vm_pkg::*;
#(
  parameter int CREDIT_W   = 10,
  parameter int MAX_CREDIT = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  vending_machine_ctrl_if.slave vm
);

  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

  vm_state_e           r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [CREDIT_W-1:0] r_rem, w_rem_nxt;
  logic [3:0]          r_code, w_code_nxt;
  logic                r_rej_vld, w_rej_vld_nxt;
  logic [3:0]          r_rej_code, w_rej_code_nxt;

  logic [CREDIT_W:0]   w_sum, w_avail, w_price;
  logic                w_coin_ok, w_coin_take, w_coin_rej, w_buy_ok;
  logic [3:0]          w_sel_code;
  logic [VAL_W-1:0]    w_sel_value;
  logic [CREDIT_W-1:0] w_rem_after;
  logic                w_chg_active;

  vm_change_sel #(.CREDIT_W(CREDIT_W)) u_change_sel (
    .i_rem   (r_rem),
    .o_code  (w_sel_code),
    .o_value (w_sel_value)
  );

  // Sum is one bit wider than credit so the overflow test can never wrap;
  // credit only ever commits values <= MAX_CREDIT.
  assign w_coin_ok   = vm.money_valid && coin_valid_code(vm.money);
  assign w_sum       = {1'b0, r_credit} + (CREDIT_W+1)'(coin_value(vm.money));
  assign w_coin_take = w_coin_ok && (w_sum <= MAX_C);
  assign w_coin_rej  = w_coin_ok && (w_sum > MAX_C);
  assign w_avail     = w_coin_take ? w_sum : {1'b0, r_credit};
  assign w_price     = (CREDIT_W+1)'(price(vm.product_code));
  assign w_buy_ok    = vm.buy && product_valid_code(vm.product_code) &&
                       (w_avail >= w_price);
  assign w_rem_after = r_rem - CREDIT_W'(w_sel_value);

  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_rem_nxt      = r_rem;
    w_code_nxt     = r_code;
    w_rej_vld_nxt  = 1'b0;
    w_rej_code_nxt = 4'd0;
    case (r_state)
      ST_IDLE: begin
        // A rejected coin is handed straight back on the next cycle
        w_rej_vld_nxt  = w_coin_rej;
        w_rej_code_nxt = w_coin_rej ? vm.money : 4'd0;
        if (w_buy_ok) begin
          w_code_nxt   = vm.product_code;
          w_rem_nxt    = w_avail[CREDIT_W-1:0] - w_price[CREDIT_W-1:0];
          w_credit_nxt = '0;
          w_state_nxt  = ST_VEND;
        end else begin
          w_credit_nxt = w_avail[CREDIT_W-1:0];
        end
      end
      ST_VEND: begin
        if (vm.product_ready) w_state_nxt = ST_CHANGE;
      end
      ST_CHANGE: begin
        if (r_rem == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_rem_nxt = w_rem_after;
          if (w_rem_after == '0) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_credit  <= '0;
      r_rem     <= '0;
      r_rej_vld <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_credit  <= w_credit_nxt;
      r_rem     <= w_rem_nxt;
      r_rej_vld <= w_rej_vld_nxt;
    end
  end

  // Code registers are only observed through their valid qualifiers
  always_ff @(posedge clk) begin
    r_code     <= w_code_nxt;
    r_rej_code <= w_rej_code_nxt;
  end

  assign w_chg_active = (r_state == ST_CHANGE) && (r_rem != '0);

  assign vm.product_valid            = (r_state == ST_VEND);
  assign vm.ready_product_code       = (r_state == ST_VEND) ? r_code : 4'd0;
  assign vm.busy                     = (r_state != ST_IDLE);
  assign vm.change_valid             = r_rej_vld || w_chg_active;
  assign vm.change_denomination_code = r_rej_vld    ? r_rej_code :
                                       w_chg_active ? w_sel_code : 4'd0;
  assign vm.no_change                = (r_state == ST_CHANGE) && (r_rem == '0);

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// Self-checking bench for vending_machine_ctrl. Expected change coins (or a
// no_change token, encoded as 16) are queued when a purchase or coin is
// driven and popped by a negedge monitor whenever the DUT returns something.
module tb_vending_machine_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  int   exp_q[$];

  localparam int NO_CHG = 16;

  vending_machine_ctrl_if vif ();

  vending_machine_ctrl #(.CREDIT_W(10), .MAX_CREDIT(1000)) dut (
    .clk (clk),
    .rst (rst),
    .vm  (vif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Greedy reference: push the coin codes the DUT must return for r units
  task automatic push_change(input int r);
    int vals[7] = '{100, 50, 20, 10, 5, 2, 1};
    int rem = r;
    if (rem == 0) exp_q.push_back(NO_CHG);
    while (rem > 0) begin
      for (int i = 0; i < 7; i++) begin
        if (vals[i] <= rem) begin
          exp_q.push_back(6 - i);
          rem -= vals[i];
          break;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (vif.change_valid || vif.no_change) begin
        int obs;
        obs = vif.change_valid ? int'(vif.change_denomination_code) : NO_CHG;
        if (vif.change_valid) check("chg_and_nochg", vif.no_change, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_return", obs, -1);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("return_evt", obs, e);
        end
      end
      if (!vif.change_valid) check("chg_code_gated", vif.change_denomination_code, 0);
      if (!vif.product_valid) check("prod_code_gated", vif.ready_product_code, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vif.money = 4'd0; vif.money_valid = 1'b0;
    vif.product_code = 4'd0; vif.buy = 1'b0; vif.product_ready = 1'b0;
  endtask

  task automatic coin(input int c);
    vif.money = 4'(c); vif.money_valid = 1'b1;
    tick();
    vif.money_valid = 1'b0;
  endtask

  task automatic buy_op(input int p);
    vif.product_code = 4'(p); vif.buy = 1'b1;
    tick();
    vif.buy = 1'b0;
  endtask

  task automatic ack();
    vif.product_ready = 1'b1;
    tick();
    vif.product_ready = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (vif.busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_wait", vif.busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pv"},   vif.product_valid, 0);
    check({tag, "_pc"},   vif.ready_product_code, 0);
    check({tag, "_busy"}, vif.busy, 0);
    check({tag, "_cv"},   vif.change_valid, 0);
    check({tag, "_cc"},   vif.change_denomination_code, 0);
    check({tag, "_nc"},   vif.no_change, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    // Reset with random inputs
    rst = 1'b0;
    repeat (2) begin
      vif.money = 4'($urandom_range(0, 15)); vif.money_valid = 1'($urandom);
      vif.product_code = 4'($urandom_range(0, 15)); vif.buy = 1'($urandom);
      vif.product_ready = 1'($urandom);
      tick();
    end
    check_all_zero("rst");
    idle_inputs();
    rst = 1'b1;
    mon_en = 1'b1;
    buy_op(0);
    check("nocredit_pv", vif.product_valid, 0);
    check("nocredit_busy", vif.busy, 0);
    tick();
    check("nocredit_busy2", vif.busy, 0);

    // Exact pay: 10+10+5 for product 2 (25)
    coin(3); coin(3); coin(2);
    buy_op(2);
    check("exact_pv", vif.product_valid, 1);
    check("exact_code", vif.ready_product_code, 2);
    check("exact_busy", vif.busy, 1);
    tick(); tick();
    check("exact_hold_pv", vif.product_valid, 1);
    check("exact_hold_code", vif.ready_product_code, 2);
    push_change(0);
    ack();
    check("exact_nochg", vif.no_change, 1);
    check("exact_pv_off", vif.product_valid, 0);
    check("exact_busy_chg", vif.busy, 1);
    tick();
    check("exact_busy_off", vif.busy, 0);
    check("exact_nochg_off", vif.no_change, 0);

    // Greedy change: 100 for product 0 (15) -> 85 = 50+20+10+5
    coin(6);
    buy_op(0);
    check("greedy_pv", vif.product_valid, 1);
    push_change(85);
    ack();
    for (int i = 0; i < 4; i++) begin
      check("greedy_busy", vif.busy, 1);
      check("greedy_cv", vif.change_valid, 1);
      tick();
    end
    check("greedy_busy_off", vif.busy, 0);
    check("greedy_cv_off", vif.change_valid, 0);

    // Insufficient credit, then coin together with buy
    coin(3);
    buy_op(9);
    check("insuff_pv", vif.product_valid, 0);
    check("insuff_busy", vif.busy, 0);
    vif.money = 4'd6; vif.money_valid = 1'b1;
    vif.product_code = 4'd9; vif.buy = 1'b1;
    tick();
    vif.money_valid = 1'b0; vif.buy = 1'b0;
    check("simul_pv", vif.product_valid, 1);
    check("simul_code", vif.ready_product_code, 9);
    push_change(10);
    ack();
    check("simul_cv", vif.change_valid, 1);
    check("simul_cc", vif.change_denomination_code, 3);
    tick();
    check("simul_busy_off", vif.busy, 0);

    // Overflow: fill to 1000, eleventh coin bounces, invalid coin ignored
    repeat (10) coin(6);
    check("fill_cv", vif.change_valid, 0);
    exp_q.push_back(6);
    coin(6);
    check("ovf_cv", vif.change_valid, 1);
    check("ovf_cc", vif.change_denomination_code, 6);
    check("ovf_busy", vif.busy, 0);
    coin(7);
    check("inv_cv", vif.change_valid, 0);
    tick();
    buy_op(9);
    check("full_pv", vif.product_valid, 1);
    push_change(900);
    ack();
    wait_idle(30);

    // Mid-transaction reset
    coin(6);
    buy_op(0);
    check("mid_pv", vif.product_valid, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_all_zero("midrst");
    ack();
    check("midrst_cv", vif.change_valid, 0);
    check("midrst_nc", vif.no_change, 0);
    check("midrst_busy", vif.busy, 0);
    tick(); tick();

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
